// File: rtl/sd_sector_streamer.sv
// sd_sector_streamer: reads NUM_SECTORS consecutive 512-byte sectors through
// sd_controller, buffers each byte in a circular FIFO and presents the bytes as
// a registered first-word-fall-through valid/ready stream. Single clock domain.

module sd_sector_streamer_chk (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  logic full
);
   // The free-space check before each read must make a push into a full FIFO impossible
   a_no_push_when_full: assert property (@(posedge clk) disable iff (reset) !(push && full));
endmodule

module sd_sector_streamer #(
   parameter int unsigned START_SECTOR = 0,
   parameter int unsigned NUM_SECTORS  = 16,
   parameter int unsigned FIFO_DEPTH   = 1024,
   parameter int unsigned ADDR_SHIFT   = 9
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        sd_ready,
   input  logic        sd_byte_available,
   input  logic [7:0]  sd_dout,
   output logic        sd_rd,
   output logic        sd_wr,
   output logic [7:0]  sd_din,
   output logic [31:0] sd_addr,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy,
   output logic        done,
   output logic [15:0] sectors_read
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C        = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] SECTOR_BYTES_C = CW'(512);
   localparam logic [CW-1:0] CNT_ONE_C      = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO_C     = CW'(0);
   localparam logic [AW-1:0] PTR_ONE_C      = AW'(1);
   localparam logic [15:0]   NUM_SECTORS_C  = 16'(NUM_SECTORS);
   localparam logic [31:0]   START_C        = 32'(START_SECTOR);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_WAIT_SPACE = 3'd1,
      S_ISSUE      = 3'd2,
      S_READ       = 3'd3,
      S_FINISH     = 3'd4,
      S_DONE       = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic          sd_rd_q, sd_rd_d;
   logic [31:0]   sd_addr_q, sd_addr_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [15:0]   sectors_read_q, sectors_read_d;
   logic [8:0]    byte_cnt_q, byte_cnt_d;
   logic          bavail_q, bavail_d;
   logic          cap_valid_q, cap_valid_d;
   logic [7:0]    cap_data_q, cap_data_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          out_valid_q, out_valid_d;
   logic [7:0]    out_data_q, out_data_d;
   logic [7:0]    mem_q [FIFO_DEPTH];

   logic          byte_rise_s;
   logic          push_s;
   logic          pop_s;
   logic          full_s;
   logic [CW-1:0] free_s;
   logic [CW-1:0] head_cnt_s;
   logic [15:0]   sectors_inc_s;
   logic [31:0]   sector_idx_s;

   // A byte is the rising edge of the strobe; a long high level still counts once.
   // A captured byte reaches the FIFO one cycle later, so it is reserved in free_s.
   assign byte_rise_s   = sd_byte_available & ~bavail_q;
   assign push_s        = cap_valid_q;
   assign pop_s         = out_valid_q & out_ready;
   assign full_s        = (count_q == DEPTH_C);
   assign free_s        = DEPTH_C - count_q - {{AW{1'b0}}, cap_valid_q};
   assign sectors_inc_s = sectors_read_q + 16'd1;
   assign sector_idx_s  = START_C + {16'd0, sectors_read_q};

   // Sector sequencing FSM: next state, byte capture and registered SD/status outputs
   always_comb begin
      state_d        = state_q;
      sd_addr_d      = sd_addr_q;
      sectors_read_d = sectors_read_q;
      byte_cnt_d     = byte_cnt_q;
      cap_valid_d    = 1'b0;
      cap_data_d     = cap_data_q;
      bavail_d       = sd_byte_available;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               sectors_read_d = 16'd0;
               if (NUM_SECTORS_C == 16'd0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_WAIT_SPACE;
               end
            end else begin
               state_d = state_q;
            end
         end
         S_WAIT_SPACE: begin
            if (sd_ready && (free_s >= SECTOR_BYTES_C)) begin
               state_d   = S_ISSUE;
               sd_addr_d = sector_idx_s << ADDR_SHIFT;
            end else begin
               state_d = S_WAIT_SPACE;
            end
         end
         S_ISSUE: begin
            // sd_rd and sd_addr are held until the controller shows it took the request
            if (!sd_ready) begin
               state_d    = S_READ;
               byte_cnt_d = 9'd0;
            end else begin
               state_d = S_ISSUE;
            end
         end
         S_READ: begin
            if (byte_rise_s) begin
               cap_valid_d = 1'b1;
               cap_data_d  = sd_dout;
               byte_cnt_d  = byte_cnt_q + 9'd1;
               if (byte_cnt_q == 9'd511) begin
                  state_d = S_FINISH;
               end else begin
                  state_d = S_READ;
               end
            end else begin
               state_d = S_READ;
            end
         end
         S_FINISH: begin
            if (sd_ready) begin
               sectors_read_d = sectors_inc_s;
               if (sectors_inc_s == NUM_SECTORS_C) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_WAIT_SPACE;
               end
            end else begin
               state_d = S_FINISH;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      sd_rd_d = (state_d == S_ISSUE);
      busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d  = (state_d == S_DONE);
   end

   // FIFO pointers, occupancy and the registered head-of-FIFO output
   always_comb begin
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE_C;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d   = rd_ptr_q + PTR_ONE_C;
         head_cnt_s = count_q - CNT_ONE_C;
      end else begin
         rd_ptr_d   = rd_ptr_q;
         head_cnt_s = count_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE_C;
         2'b01:   count_d = count_q - CNT_ONE_C;
         default: count_d = count_q;
      endcase
      // Only bytes already in storage feed the output, which gives the two-cycle
      // capture-to-valid latency and keeps out_data stable while stalled.
      out_valid_d = (head_cnt_s != CNT_ZERO_C);
      if (out_valid_d) begin
         out_data_d = mem_q[rd_ptr_d];
      end else begin
         out_data_d = out_data_q;
      end
   end

   // Control and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         sd_rd_q        <= 1'b0;
         sd_addr_q      <= 32'd0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         sectors_read_q <= 16'd0;
         byte_cnt_q     <= 9'd0;
         bavail_q       <= 1'b0;
         cap_valid_q    <= 1'b0;
         cap_data_q     <= 8'd0;
         wr_ptr_q       <= {AW{1'b0}};
         rd_ptr_q       <= {AW{1'b0}};
         count_q        <= CNT_ZERO_C;
         out_valid_q    <= 1'b0;
         out_data_q     <= 8'd0;
      end else begin
         state_q        <= state_d;
         sd_rd_q        <= sd_rd_d;
         sd_addr_q      <= sd_addr_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         sectors_read_q <= sectors_read_d;
         byte_cnt_q     <= byte_cnt_d;
         bavail_q       <= bavail_d;
         cap_valid_q    <= cap_valid_d;
         cap_data_q     <= cap_data_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         out_valid_q    <= out_valid_d;
         out_data_q     <= out_data_d;
      end
   end

   // FIFO storage; contents are qualified by count_q so no reset is needed
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= cap_data_q;
      end
   end

   sd_sector_streamer_chk u_chk (
      .clk   (clk),
      .reset (reset),
      .push  (push_s),
      .full  (full_s)
   );

   assign sd_rd        = sd_rd_q;
   assign sd_wr        = 1'b0;
   assign sd_din       = 8'd0;
   assign sd_addr      = sd_addr_q;
   assign out_data     = out_data_q;
   assign out_valid    = out_valid_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign sectors_read = sectors_read_q;
endmodule

// File: tb/tb_sd_sector_streamer.sv
// Bench for sd_sector_streamer: an SD controller model pushes each driven byte into
// a scoreboard queue, and a monitor compares every accepted output byte against it.
module tb_sd_sector_streamer;
   logic        clk = 1'b0;
   logic        reset, a_start, b_start;
   logic        sd_ready, sd_byte_available;
   logic [7:0]  sd_dout;
   logic        sd_rd, sd_wr;
   logic [7:0]  sd_din;
   logic [31:0] sd_addr;
   logic [7:0]  out_data;
   logic        out_valid, out_ready, busy, done;
   logic [15:0] sectors_read;
   logic        b_sd_rd, b_sd_wr, b_out_valid, b_busy, b_done;
   logic [7:0]  b_sd_din, b_out_data;
   logic [31:0] b_sd_addr;
   logic [15:0] b_sectors_read;

   int          n_cmp = 0, n_bad = 0, n_popped = 0, rd_bad = 0, rd_nr_run = 0;
   int          rd_count = 0, cur_byte = 0, rdy_mode = 0;
   logic        sd_abort = 1'b0, sd_busy_m = 1'b0;
   logic [7:0]  exp_q [$];
   logic [31:0] addr_log [$];

   always #5 clk = ~clk;

   sd_sector_streamer #(.START_SECTOR(5), .NUM_SECTORS(3), .FIFO_DEPTH(1024), .ADDR_SHIFT(9)) dut (
      .clk(clk), .reset(reset), .start(a_start), .sd_ready(sd_ready),
      .sd_byte_available(sd_byte_available), .sd_dout(sd_dout), .sd_rd(sd_rd), .sd_wr(sd_wr),
      .sd_din(sd_din), .sd_addr(sd_addr), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .done(done), .sectors_read(sectors_read));

   sd_sector_streamer #(.START_SECTOR(0), .NUM_SECTORS(0), .FIFO_DEPTH(1024), .ADDR_SHIFT(9)) dut_zero (
      .clk(clk), .reset(reset), .start(b_start), .sd_ready(1'b1),
      .sd_byte_available(1'b0), .sd_dout(8'h00), .sd_rd(b_sd_rd), .sd_wr(b_sd_wr),
      .sd_din(b_sd_din), .sd_addr(b_sd_addr), .out_data(b_out_data), .out_valid(b_out_valid),
      .out_ready(1'b0), .busy(b_busy), .done(b_done), .sectors_read(b_sectors_read));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] pat(input int s, input int k);
      return 8'(s * 37 + k * 5 + 3);
   endfunction

   // Sector s lives at byte address s*512: 5 -> 0xA00, 6 -> 0xC00, 7 -> 0xE00
   task automatic check_addrs(input string tag);
      for (int i = 0; i < addr_log.size(); i++)
         check($sformatf("%s_addr%0d", tag, i), addr_log[i], 32'h0000_0A00 + 32'(i) * 32'h0000_0200);
   endtask

   // SD controller model: answers each read request with 512 strobed bytes
   initial begin : sd_model
      int sector, hold;
      sd_ready = 1'b1;
      sd_byte_available = 1'b0;
      sd_dout = 8'h00;
      forever begin
         tick();
         if (sd_rd && !sd_abort) begin
            sd_busy_m = 1'b1;
            cur_byte = 0;
            rd_count++;
            addr_log.push_back(sd_addr);
            sector = int'(sd_addr >> 9);
            hold = (sector == 5) ? 4 : 1;
            tick();
            tick();
            sd_ready = 1'b0;
            while (cur_byte < 512 && !sd_abort) begin
               tick();
               tick();
               if (!sd_abort) begin
                  sd_dout = pat(sector, cur_byte);
                  sd_byte_available = 1'b1;
                  exp_q.push_back(sd_dout);
                  repeat (hold) tick();
                  sd_byte_available = 1'b0;
                  cur_byte++;
               end
            end
            tick();
            sd_ready = 1'b1;
            sd_busy_m = 1'b0;
         end
      end
   end

   // Consumer ready: 0 = stalled, 1 = always ready, otherwise random
   initial begin : rdy_drv
      out_ready = 1'b0;
      forever begin
         tick();
         case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: compare accepted bytes with the scoreboard and watch sd_rd protocol
   initial begin : monitor
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (!reset && out_valid && out_ready) begin
            n_popped++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL out_extra: got byte 0x%0h, expected no byte", out_data);
            end else begin
               e = exp_q.pop_front();
               check("out_byte", 32'(out_data), 32'(e));
            end
         end
         if (sd_rd && !sd_ready) rd_nr_run++;
         else rd_nr_run = 0;
         if (rd_nr_run > 1) rd_bad++;
         if (sd_rd && !busy) rd_bad++;
         if (b_sd_rd) rd_bad++;
      end
   end

   initial begin : main
      int t, base;
      reset = 1'b1;
      a_start = 1'b0;
      b_start = 1'b0;
      repeat (3) tick();
      check("rst_sd_rd", 32'(sd_rd), 32'd0);
      check("rst_sd_wr", 32'(sd_wr), 32'd0);
      check("rst_sd_din", 32'(sd_din), 32'd0);
      check("rst_sd_addr", sd_addr, 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sectors", 32'(sectors_read), 32'd0);
      reset = 1'b0;

      // NUM_SECTORS = 0: done one cycle after start, no SD access
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      check("zero_done", 32'(b_done), 32'd1);
      check("zero_busy", 32'(b_busy), 32'd0);
      check("zero_sd_rd", 32'(b_sd_rd), 32'd0);
      tick();
      check("zero_idle_outs", {b_sd_wr, b_out_valid, b_sd_din, b_out_data, b_sectors_read[13:0]}, 32'd0);
      check("zero_addr", b_sd_addr, 32'd0);

      // Run A: consumer stalled, FIFO fills after two sectors and the third waits
      rdy_mode = 0;
      rd_count = 0;
      addr_log.delete();
      base = n_popped;
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      check("a_busy", 32'(busy), 32'd1);
      t = 0;
      while (sectors_read != 16'd2 && t < 20000) begin tick(); t++; end
      check("a_two_sectors", 32'(sectors_read), 32'd2);
      repeat (300) tick();
      check("a_stall_rd_count", 32'(rd_count), 32'd2);
      check("a_stall_busy", 32'(busy), 32'd1);
      check("a_stall_sd_rd", 32'(sd_rd), 32'd0);
      check("a_stall_valid", 32'(out_valid), 32'd1);
      check("a_stall_head", 32'(out_data), 32'(pat(5, 0)));
      rdy_mode = 1;
      t = 0;
      while (!done && t < 20000) begin tick(); t++; end
      check("a_done", 32'(done), 32'd1);
      t = 0;
      while ((exp_q.size() != 0 || out_valid) && t < 5000) begin tick(); t++; end
      check("a_left_over", 32'(exp_q.size()), 32'd0);
      check("a_bytes", 32'(n_popped - base), 32'd1536);
      check("a_sectors", 32'(sectors_read), 32'd3);
      check("a_busy_end", 32'(busy), 32'd0);
      check("a_rd_count", 32'(rd_count), 32'd3);
      check_addrs("a");

      // Run B: restart from DONE, then reset in the middle of sector 5
      rd_count = 0;
      addr_log.delete();
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      check("b_restart_sectors", 32'(sectors_read), 32'd0);
      check("b_restart_done", 32'(done), 32'd0);
      t = 0;
      while (!(rd_count == 1 && cur_byte >= 200) && t < 20000) begin tick(); t++; end
      check("b_at_byte200", 32'(cur_byte), 32'd200);
      sd_abort = 1'b1;
      reset = 1'b1;
      tick();
      check("b_rst_sd_rd", 32'(sd_rd), 32'd0);
      check("b_rst_sd_addr", sd_addr, 32'd0);
      check("b_rst_out_valid", 32'(out_valid), 32'd0);
      check("b_rst_out_data", 32'(out_data), 32'd0);
      check("b_rst_busy", 32'(busy), 32'd0);
      check("b_rst_done", 32'(done), 32'd0);
      check("b_rst_sectors", 32'(sectors_read), 32'd0);
      reset = 1'b0;
      t = 0;
      while (sd_busy_m && t < 5000) begin tick(); t++; end
      exp_q.delete();
      sd_abort = 1'b0;
      repeat (5) tick();
      check("b_fifo_discarded", 32'(out_valid), 32'd0);

      // Run C: fresh start from sector 5, start while busy, near-full push/pop
      rdy_mode = 0;
      rd_count = 0;
      addr_log.delete();
      base = n_popped;
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      t = 0;
      while (rd_count < 1 && t < 5000) begin tick(); t++; end
      repeat (20) tick();
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      check("c_busy_after_start", 32'(busy), 32'd1);
      t = 0;
      while (!(rd_count == 2 && cur_byte >= 480) && t < 20000) begin tick(); t++; end
      rdy_mode = 2;
      t = 0;
      while (!done && t < 20000) begin tick(); t++; end
      check("c_done", 32'(done), 32'd1);
      t = 0;
      while ((exp_q.size() != 0 || out_valid) && t < 10000) begin tick(); t++; end
      check("c_left_over", 32'(exp_q.size()), 32'd0);
      check("c_bytes", 32'(n_popped - base), 32'd1536);
      check("c_sectors", 32'(sectors_read), 32'd3);
      check("c_rd_count", 32'(rd_count), 32'd3);
      check_addrs("c");
      check("sd_rd_protocol", 32'(rd_bad), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
